// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider (a / b). Special operands resolve in one
// cycle; normal operands use a 25-step radix-2 restoring mantissa divider.
// The quotient is truncated, and denormal inputs are flushed to signed zero.
module fp_divider #(
  parameter logic [31:0] QNAN_VALUE = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t       state_q;
  logic [4:0]   cnt_q;
  logic [25:0]  rem_q;
  logic [24:0]  quo_q;
  logic [23:0]  mb_q;
  logic [7:0]   ea_q;
  logic [7:0]   eb_q;
  logic         sign_q;
  logic         ready_q;
  logic         done_q;
  logic [31:0]  result_q;
  logic         ovf_q;
  logic         unf_q;
  logic         dz_q;
  logic         inv_q;

  assign ready       = ready_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dz_q;
  assign invalid     = inv_q;

  // Operand classification and the special-case result table
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sign_in;
  logic        sp_hit, sp_inv, sp_dz;
  logic [31:0] sp_res;

  always_comb begin
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    a_zero  = (a[30:23] == 8'h00);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    b_zero  = (b[30:23] == 8'h00);
    sign_in = a[31] ^ b[31];
    sp_hit  = 1'b1;
    sp_inv  = 1'b0;
    sp_dz   = 1'b0;
    sp_res  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = QNAN_VALUE;
      sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_res = {sign_in, 8'hFF, 23'h0};
    end else if (b_zero) begin
      sp_res = {sign_in, 8'hFF, 23'h0};
      sp_dz  = 1'b1;
    end else if (a_zero || b_inf) begin
      sp_res = {sign_in, 31'h0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // One restoring step: subtract divisor if it fits, shift remainder left
  logic        step_ge;
  logic [25:0] step_diff;
  logic [25:0] rem_d;
  logic [24:0] quo_d;

  always_comb begin
    step_ge   = rem_q >= {2'b00, mb_q};
    step_diff = step_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    rem_d     = step_diff << 1;
    quo_d     = {quo_q[23:0], step_ge};
  end

  // Normalisation of the quotient and exponent range checks
  logic signed [9:0] exp_d;
  logic [22:0]       man_d;
  logic [31:0]       norm_res_d;
  logic              norm_ovf_d;
  logic              norm_unf_d;

  always_comb begin
    exp_d = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    if (quo_q[24]) begin
      man_d = quo_q[23:1];
    end else begin
      man_d = quo_q[22:0];
      exp_d = exp_d - 10'sd1;
    end
    norm_ovf_d = 1'b0;
    norm_unf_d = 1'b0;
    if (exp_d >= 10'sd255) begin
      norm_ovf_d = 1'b1;
      norm_res_d = {sign_q, 8'hFF, 23'h0};
    end else if (exp_d <= 10'sd0) begin
      norm_unf_d = 1'b1;
      norm_res_d = '0;
    end else begin
      norm_res_d = {sign_q, exp_d[7:0], man_d};
    end
  end

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mb_q     <= '0;
      ea_q     <= '0;
      eb_q     <= '0;
      sign_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dz_q     <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sign_q   <= sign_in;
            ea_q     <= a[30:23];
            eb_q     <= b[30:23];
            mb_q     <= {1'b1, b[22:0]};
            rem_q    <= {2'b01, a[22:0]};
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= sp_res;
            dz_q     <= sp_dz;
            inv_q    <= sp_inv;
            state_q  <= sp_hit ? S_DONE : S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd24) state_q <= S_NORM;
        end
        S_NORM: begin
          result_q <= norm_res_d;
          ovf_q    <= norm_ovf_d;
          unf_q    <= norm_unf_d;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: drivers push expected results, a monitor
// pops and compares on every done pulse, including accept-to-done latency.
module tb_fp_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  fp_divider #(.QNAN_VALUE(32'h7FC0_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (op_a),
    .b           (op_b),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero),
    .invalid     (invalid)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, div_by_zero, invalid}
    int unsigned acc;   // edge index at which start was accepted
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        done_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per done pulse
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      chk("done_pulse_width", {31'h0, done_prev}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags", {28'h0, overflow, underflow, div_by_zero, invalid}, {28'h0, e.flg});
        chk("latency", cyc - e.acc, e.lat);
      end
    end
    done_prev = done;
  end

  // Issue one operation at a negedge; caller is at a negedge
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] er, input logic [3:0] ef,
                       input int unsigned lat);
    int unsigned n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", {31'h0, ready}, 32'h1);
    op_a  = ta;
    op_b  = tb_v;
    start = 1'b1;
    sb.push_back('{er, ef, cyc + 1, lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 32'h0);
    @(negedge clk);
  endtask

  task automatic chk_idle_reset();
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {28'h0, overflow, underflow, div_by_zero, invalid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    chk_idle_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Normal path
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27); drain();
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27); drain();
    do_op(32'hC0800000, 32'h3F000000, 32'hC1000000, 4'b0000, 27); drain();
    // Specials
    do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1); drain();
    do_op(32'hBF800000, 32'h80000000, 32'h7F800000, 4'b0010, 1); drain();
    do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1); drain();
    do_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001, 1); drain();
    do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, 1); drain();
    do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1); drain();
    do_op(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1); drain();
    do_op(32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1); drain();
    do_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1); drain();
    // Range
    do_op(32'h7F000000, 32'h00800000, 32'h7F800000, 4'b1000, 27); drain();
    do_op(32'h00800000, 32'h7F000000, 32'h00000000, 4'b0100, 27); drain();

    // Handshake: later starts with changing operands are ignored while busy
    op_a  = 32'h40C00000;
    op_b  = 32'h40000000;
    start = 1'b1;
    sb.push_back('{32'h40400000, 4'b0000, cyc + 1, 27});
    for (int unsigned i = 0; i < 26; i++) begin
      @(negedge clk);
      chk("busy_ready_low", {31'h0, ready}, 32'h0);
      op_a = 32'h3F800000 + i;
    end
    start = 1'b0;
    drain();

    // Back-to-back: start held high, re-accepted right after DONE
    op_a  = 32'h3F800000;
    op_b  = 32'h00000000;
    start = 1'b1;
    sb.push_back('{32'h7F800000, 4'b0010, cyc + 1, 1});
    sb.push_back('{32'h7F800000, 4'b0010, cyc + 3, 1});
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of DIVIDE (cnt == 10), then a clean operation
    op_a  = 32'h3F800000;
    op_b  = 32'h40400000;
    start = 1'b1;
    acc   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_reset();
    rst_n = 1'b1;
    @(negedge clk);
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27); drain();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
